// File: rtl/rst_seq_sync_if.sv
// Reset-sequencer signal bundle: software reset request in, staged resets and cause out.
// All signals are levels; the sequencer samples sw_rst_req_i on clk_i and drives the rest from flops.
interface rst_seq_sync_if;
  logic       sw_rst_req_i;
  logic       rst_periph_no;
  logic       rst_core_no;
  logic       rst_done_o;
  logic [1:0] rst_cause_o;

  modport master (
    output sw_rst_req_i,
    input  rst_periph_no,
    input  rst_core_no,
    input  rst_done_o,
    input  rst_cause_o
  );

  modport slave (
    input  sw_rst_req_i,
    output rst_periph_no,
    output rst_core_no,
    output rst_done_o,
    output rst_cause_o
  );
endinterface

// File: rtl/rst_seq_sync.sv
// Staged reset sequencer: synchronised release, hold, peripheral-then-core release.
// Optional software reset is enabled by defining RST_SEQ_SW_RESET_EN.
module rst_seq_sync #(
  parameter int SyncStages    = 2,
  parameter int HoldCycles    = 16,
  parameter int StageGap      = 4,
  parameter int SwPulseCycles = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  rst_seq_sync_if.slave       bus,
  output logic [2:0]          dbg_state_o
);

  localparam int MaxA   = (HoldCycles > StageGap) ? HoldCycles : StageGap;
  localparam int MaxCnt = (MaxA > SwPulseCycles) ? MaxA : SwPulseCycles;
  localparam int CntW   = $clog2(MaxCnt) + 1;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_HOLD   = 3'd1,
    ST_PERIPH = 3'd2,
`ifdef RST_SEQ_SW_RESET_EN
    ST_RUN    = 3'd3,
    ST_SW     = 3'd4
`else
    ST_RUN    = 3'd3
`endif
  } state_e;

  logic [SyncStages-1:0] sync_q;
  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  periph_q, periph_d;
  logic                  core_q, core_d;
  logic                  done_q;
  logic [1:0]            cause_q, cause_d;

  // Release synchroniser: clears asynchronously, shifts ones in on clk_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_RESET;
      cnt_q    <= '0;
      periph_q <= 1'b0;
      core_q   <= 1'b0;
      done_q   <= 1'b0;
      cause_q  <= 2'b01;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      periph_q <= periph_d;
      core_q   <= core_d;
      done_q   <= core_d;
      cause_q  <= cause_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    periph_d = periph_q;
    core_d   = core_q;
    cause_d  = cause_q;
    unique case (state_q)
      ST_RESET: begin
        periph_d = 1'b0;
        core_d   = 1'b0;
        cnt_d    = '0;
        if (sync_q[SyncStages-1]) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt_q == CntW'(HoldCycles - 1)) begin
          state_d  = ST_PERIPH;
          cnt_d    = '0;
          periph_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PERIPH: begin
        if (cnt_q == CntW'(StageGap - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          core_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
`ifdef RST_SEQ_SW_RESET_EN
        // Level-sensitive: a request still high on return to RUN retriggers.
        if (bus.sw_rst_req_i) begin
          state_d  = ST_SW;
          periph_d = 1'b0;
          core_d   = 1'b0;
          cause_d  = 2'b10;
        end
`endif
      end
`ifdef RST_SEQ_SW_RESET_EN
      ST_SW: begin
        if (cnt_q == CntW'(SwPulseCycles - 1)) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_RESET;
        cnt_d   = '0;
      end
    endcase
  end

`ifndef RST_SEQ_SW_RESET_EN
  logic sw_req_unused;
  assign sw_req_unused = bus.sw_rst_req_i;
`endif

  assign bus.rst_periph_no = periph_q;
  assign bus.rst_core_no   = core_q;
  assign bus.rst_done_o    = done_q;
  assign bus.rst_cause_o   = cause_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_rst_seq_sync.sv
// Bench for rst_seq_sync: default instance (2/16/4) and a fast instance (3/1/1) share clk and rst_n.
module tb_rst_seq_sync;

  logic       clk;
  logic       rst_n;
  logic [2:0] a_dbg, b_dbg;
  int         checks = 0;
  int         errors = 0;
  int         cur_edge = 0;

  rst_seq_sync_if a_if ();
  rst_seq_sync_if b_if ();

  rst_seq_sync #(.SyncStages(2), .HoldCycles(16), .StageGap(4), .SwPulseCycles(8)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .bus(a_if.slave), .dbg_state_o(a_dbg)
  );

  rst_seq_sync #(.SyncStages(3), .HoldCycles(1), .StageGap(1), .SwPulseCycles(8)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .bus(b_if.slave), .dbg_state_o(b_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int   e;
    logic ap, ac, bp, bc;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge %0d got %b want %b", name, cur_edge, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ap, input logic ac, input logic bp,
                         input logic bc, input logic [1:0] acause, input logic [1:0] bcause);
    chk({tag, " a_periph"}, {1'b0, a_if.rst_periph_no}, {1'b0, ap});
    chk({tag, " a_core"},   {1'b0, a_if.rst_core_no},   {1'b0, ac});
    chk({tag, " a_done"},   {1'b0, a_if.rst_done_o},    {1'b0, ac});
    chk({tag, " a_cause"},  a_if.rst_cause_o,           acause);
    chk({tag, " b_periph"}, {1'b0, b_if.rst_periph_no}, {1'b0, bp});
    chk({tag, " b_core"},   {1'b0, b_if.rst_core_no},   {1'b0, bc});
    chk({tag, " b_done"},   {1'b0, b_if.rst_done_o},    {1'b0, bc});
    chk({tag, " b_cause"},  b_if.rst_cause_o,           bcause);
  endtask

  // Advance to just after edge e (sampled on the following falling edge).
  task automatic advance_to(input int e);
    if (e > cur_edge) begin
      while (cur_edge < e) begin
        @(posedge clk);
        cur_edge++;
      end
      @(negedge clk);
    end
  endtask

  task automatic release_rst();
    rst_n    = 1'b1;
    cur_edge = 0;
  endtask

  task automatic apply_table(input string tag);
    for (int i = 0; i < 10; i++) begin
      advance_to(tbl[i].e);
      chk_out(tag, tbl[i].ap, tbl[i].ac, tbl[i].bp, tbl[i].bc, 2'b01, 2'b01);
    end
  endtask

  // Per-cycle invariants: core released implies periph released; done tracks core.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("a_core_implies_periph", {1'b0, a_if.rst_core_no & ~a_if.rst_periph_no}, 2'b00);
      chk("a_done_eq_core", {1'b0, a_if.rst_done_o}, {1'b0, a_if.rst_core_no});
      chk("b_core_implies_periph", {1'b0, b_if.rst_core_no & ~b_if.rst_periph_no}, 2'b00);
      chk("b_done_eq_core", {1'b0, b_if.rst_done_o}, {1'b0, b_if.rst_core_no});
    end
  end

  initial begin
    // release edges: A periph 19 core 23; B periph 5 core 6
    tbl[0] = '{1,  0, 0, 0, 0};
    tbl[1] = '{3,  0, 0, 0, 0};
    tbl[2] = '{4,  0, 0, 0, 0};
    tbl[3] = '{5,  0, 0, 1, 0};
    tbl[4] = '{6,  0, 0, 1, 1};
    tbl[5] = '{18, 0, 0, 1, 1};
    tbl[6] = '{19, 1, 0, 1, 1};
    tbl[7] = '{22, 1, 0, 1, 1};
    tbl[8] = '{23, 1, 1, 1, 1};
    tbl[9] = '{40, 1, 1, 1, 1};

    rst_n = 1'b0;
    a_if.sw_rst_req_i = 1'b0;
    b_if.sw_rst_req_i = 1'b0;

    // power-up: held low 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_out("por_low", 0, 0, 0, 0, 2'b01, 2'b01);
    end
    release_rst();
    apply_table("powerup");

    // drop while in RUN, asynchronously mid-cycle
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_out("run_drop", 0, 0, 0, 0, 2'b01, 2'b01);
    repeat (3) @(negedge clk);
    release_rst();
    apply_table("after_run_drop");

    // sub-period reset pulse
    rst_n = 1'b0;
    #2 chk_out("short_pulse", 0, 0, 0, 0, 2'b01, 2'b01);
    #1 release_rst();
    advance_to(9);
    chk_out("pre_hold_drop", 0, 0, 1, 1, 2'b01, 2'b01);
    // drop mid-clock at edge 10 while A is in HOLD
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_out("hold_drop", 0, 0, 0, 0, 2'b01, 2'b01);
    repeat (3) @(negedge clk);
    release_rst();
    apply_table("after_hold_drop");

`ifdef RST_SEQ_SW_RESET_EN
    // one-cycle software request in RUN at edge 41
    a_if.sw_rst_req_i = 1'b1;
    b_if.sw_rst_req_i = 1'b1;
    advance_to(41);
    a_if.sw_rst_req_i = 1'b0;
    b_if.sw_rst_req_i = 1'b0;
    chk_out("sw_entry", 0, 0, 0, 0, 2'b10, 2'b10);
    advance_to(49);
    chk_out("sw_49", 0, 0, 0, 0, 2'b10, 2'b10);
    advance_to(50);
    chk_out("sw_50", 0, 0, 1, 0, 2'b10, 2'b10);
    advance_to(51);
    chk_out("sw_51", 0, 0, 1, 1, 2'b10, 2'b10);
    advance_to(64);
    chk_out("sw_64", 0, 0, 1, 1, 2'b10, 2'b10);
    advance_to(65);
    chk_out("sw_65", 1, 0, 1, 1, 2'b10, 2'b10);
    advance_to(68);
    chk_out("sw_68", 1, 0, 1, 1, 2'b10, 2'b10);
    advance_to(69);
    chk_out("sw_69", 1, 1, 1, 1, 2'b10, 2'b10);

    // external reset restores cause 01
    rst_n = 1'b0;
    #1 chk_out("sw_then_por", 0, 0, 0, 0, 2'b01, 2'b01);
    repeat (2) @(negedge clk);
    release_rst();

    // request held through HOLD and PERIPH on A: ignored
    advance_to(4);
    a_if.sw_rst_req_i = 1'b1;
    advance_to(18);
    chk_out("ign_18", 0, 0, 1, 1, 2'b01, 2'b01);
    advance_to(19);
    chk_out("ign_19", 1, 0, 1, 1, 2'b01, 2'b01);
    advance_to(22);
    a_if.sw_rst_req_i = 1'b0;
    chk_out("ign_22", 1, 0, 1, 1, 2'b01, 2'b01);
    advance_to(23);
    chk_out("ign_23", 1, 1, 1, 1, 2'b01, 2'b01);
`else
    // request in RUN has no effect without the software reset feature
    a_if.sw_rst_req_i = 1'b1;
    b_if.sw_rst_req_i = 1'b1;
    advance_to(45);
    chk_out("sw_ignored", 1, 1, 1, 1, 2'b01, 2'b01);
    advance_to(60);
    chk_out("sw_ignored_late", 1, 1, 1, 1, 2'b01, 2'b01);
    a_if.sw_rst_req_i = 1'b0;
    b_if.sw_rst_req_i = 1'b0;
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
